// File: rtl/filtez.sv
// Zero-predictor filter: sums bli[i]*dlti[i] over NTAPS taps and returns acc >>> SHIFT.
// Optional FILTEZ_KEY_LOCK_EN adds working_key, which seeds the accumulator with (working_key ^ KEY_VALUE) << SHIFT.
module filtez #(
    parameter int         NTAPS     = 6,
    parameter int         ADDR_W    = 3,
    parameter int         SHIFT     = 14,
    parameter logic [7:0] KEY_VALUE = 8'hA5
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] bli_address0,
    output logic              bli_ce0,
    input  logic [31:0]       bli_q0,
    output logic [ADDR_W-1:0] dlti_address0,
    output logic              dlti_ce0,
    input  logic [31:0]       dlti_q0,
    output logic [31:0]       ap_return
`ifdef FILTEZ_KEY_LOCK_EN
    ,
    input  logic [7:0]        working_key
`endif
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_MUL   = 5'b00100,
        S_ACC   = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    // One extra counter bit so the counter can reach NTAPS when NTAPS == 2^ADDR_W.
    localparam logic [ADDR_W:0] TAP_END = (ADDR_W + 1)'(NTAPS);
    localparam logic [ADDR_W:0] TAP_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   i;
    logic [63:0]       acc;
    logic [63:0]       prod_reg;
    logic [63:0]       acc_init;
    logic [63:0]       bli_ext;
    logic [63:0]       dlti_ext;

`ifdef FILTEZ_KEY_LOCK_EN
    assign acc_init = {56'b0, working_key ^ KEY_VALUE} << SHIFT;
`else
    assign acc_init = '0;
`endif

    // Low 64 bits of the product of sign-extended operands equal the exact signed product.
    assign bli_ext  = {{32{bli_q0[31]}}, bli_q0};
    assign dlti_ext = {{32{dlti_q0[31]}}, dlti_q0};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_IDLE;
            i         <= '0;
            acc       <= '0;
            prod_reg  <= '0;
            ap_return <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        i   <= '0;
                        acc <= acc_init;
                    end
                end
                S_MUL: prod_reg <= bli_ext * dlti_ext;
                S_ACC: begin
                    acc <= acc + prod_reg;
                    i   <= i + TAP_ONE;
                end
                S_DONE: ap_return <= acc[SHIFT+31:SHIFT];
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state    = state;
        bli_address0  = '0;
        bli_ce0       = 1'b0;
        dlti_address0 = '0;
        dlti_ce0      = 1'b0;
        ap_done       = 1'b0;
        ap_idle       = 1'b0;
        ap_ready      = 1'b0;
        case (state)
            S_IDLE: begin
                // ap_done also reads high while idle without a request, as the handshake expects.
                ap_done = !ap_start;
                ap_idle = !ap_start;
                if (ap_start) next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (i == TAP_END) begin
                    next_state = S_DONE;
                end else begin
                    bli_address0  = i[ADDR_W-1:0];
                    dlti_address0 = i[ADDR_W-1:0];
                    bli_ce0       = 1'b1;
                    dlti_ce0      = 1'b1;
                    next_state    = S_MUL;
                end
            end
            S_MUL:  next_state = S_ACC;
            S_ACC:  next_state = S_ISSUE;
            S_DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_filtez.sv
// Directed testbench for filtez: latency, arithmetic, address sequencing, reset and back-to-back runs.
// Under FILTEZ_KEY_LOCK_EN it also exercises the working_key offset.
module tb_filtez;

    localparam logic [7:0] KEY = 8'hA5;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [2:0]  bli_address0;
    logic        bli_ce0;
    logic [31:0] bli_q0;
    logic [2:0]  dlti_address0;
    logic        dlti_ce0;
    logic [31:0] dlti_q0;
    logic [31:0] ap_return;
`ifdef FILTEZ_KEY_LOCK_EN
    logic [7:0]  working_key;
`endif

    logic [31:0] bli_mem  [0:7];
    logic [31:0] dlti_mem [0:7];

    int          errors;
    int          checks;

    int          ce_cnt;
    int          ce_cycle [0:7];
    logic [2:0]  ce_addr  [0:7];
    logic        ce_split;
    logic        ready_early;
    logic        ready_at_done;
    logic        ready_after;

    filtez dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .bli_address0  (bli_address0),
        .bli_ce0       (bli_ce0),
        .bli_q0        (bli_q0),
        .dlti_address0 (dlti_address0),
        .dlti_ce0      (dlti_ce0),
        .dlti_q0       (dlti_q0),
        .ap_return     (ap_return)
`ifdef FILTEZ_KEY_LOCK_EN
        ,
        .working_key   (working_key)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Single-port RAM models with one cycle of read latency.
    always @(posedge ap_clk) begin
        if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
        if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
    end

    task automatic clear_mem();
        for (int k = 0; k < 8; k++) begin
            bli_mem[k]  = 32'd0;
            dlti_mem[k] = 32'd0;
        end
    endtask

    // Pulses ap_start in cycle 0 and follows the run until ap_done, recording RAM accesses.
    task automatic do_run(output int done_cycle, output logic [31:0] result);
        ce_cnt      = 0;
        ce_split    = 1'b0;
        ready_early = 1'b0;
        ready_at_done = 1'b0;
        done_cycle  = -1;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge ap_clk);
            if (bli_ce0 !== dlti_ce0 || (bli_ce0 && bli_address0 !== dlti_address0)) ce_split = 1'b1;
            if (bli_ce0) begin
                if (ce_cnt < 8) begin
                    ce_cycle[ce_cnt] = c;
                    ce_addr[ce_cnt]  = bli_address0;
                end
                ce_cnt++;
            end
            if (ap_done) begin
                done_cycle    = c;
                ready_at_done = ap_ready;
                break;
            end
            if (ap_ready) ready_early = 1'b1;
        end
        @(posedge ap_clk);
        #1;
        result      = ap_return;
        ready_after = ap_ready;
    endtask

    task automatic test_reset();
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (ap_return !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_return: got %h expected %h", ap_return, 32'd0);
        end
        checks++;
        if ({ap_idle, ap_done, ap_ready, bli_ce0, dlti_ce0} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: idle/done/ready/ce/ce got %b expected %b",
                     {ap_idle, ap_done, ap_ready, bli_ce0, dlti_ce0}, 5'b11000);
        end
    endtask

    task automatic test_zero_coeffs();
        int          dc;
        logic [31:0] r;
        clear_mem();
        for (int k = 0; k < 6; k++) dlti_mem[k] = 32'h1234_0000 + k * 32'h0101_0F0F;
        do_run(dc, r);
        checks++;
        if (dc !== 20) begin
            errors++;
            $display("[TB] FAIL zero_latency: done cycle %0d expected %0d", dc, 20);
        end
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("[TB] FAIL zero_return: got %h expected %h", r, 32'd0);
        end
        checks++;
        if ({ready_early, ready_at_done, ready_after} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL zero_ready: early/done/after got %b expected %b",
                     {ready_early, ready_at_done, ready_after}, 3'b010);
        end
    endtask

    task automatic test_unit_tap();
        int          dc;
        logic [31:0] r;
        clear_mem();
        bli_mem[0]  = 32'd16384;
        dlti_mem[0] = 32'd1;
        do_run(dc, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("[TB] FAIL unit_return: got %h expected %h", r, 32'd1);
        end
    endtask

    task automatic test_negative();
        int          dc;
        logic [31:0] r;
        clear_mem();
        bli_mem[0]  = 32'hFFFF_C000;
        dlti_mem[0] = 32'd3;
        do_run(dc, r);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL neg_return: got %h expected %h", r, 32'hFFFF_FFFD);
        end
        bli_mem[0]  = 32'hFFFF_FFFF;
        dlti_mem[0] = 32'd1;
        do_run(dc, r);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL floor_return: got %h expected %h", r, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_full_scale();
        int          dc;
        logic [31:0] r;
        clear_mem();
        for (int k = 0; k < 6; k++) begin
            bli_mem[k]  = 32'd32767;
            dlti_mem[k] = 32'd32767;
        end
        // 6 * 32767^2 = 6442057734, floor(/16384) = 393192
        do_run(dc, r);
        checks++;
        if (r !== 32'd393192) begin
            errors++;
            $display("[TB] FAIL full_return: got %0d expected %0d", r, 393192);
        end
        checks++;
        if (ce_cnt !== 6 || ce_split !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_ce_count: reads %0d split %b expected 6 split 0", ce_cnt, ce_split);
        end
        for (int k = 0; k < 6 && k < ce_cnt; k++) begin
            checks++;
            if (ce_cycle[k] !== 1 + 3 * k || ce_addr[k] !== 3'(k)) begin
                errors++;
                $display("[TB] FAIL full_read_%0d: cycle %0d addr %0d expected cycle %0d addr %0d",
                         k, ce_cycle[k], ce_addr[k], 1 + 3 * k, k);
            end
        end
    endtask

    task automatic test_mid_reset();
        int          dc;
        logic [31:0] r;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (ap_return !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_return: got %h expected %h", ap_return, 32'd0);
        end
        checks++;
        if ({ap_idle, bli_ce0, dlti_ce0} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl: idle/ce/ce got %b expected %b",
                     {ap_idle, bli_ce0, dlti_ce0}, 3'b100);
        end
        clear_mem();
        bli_mem[5]  = 32'd32768;
        dlti_mem[5] = 32'd2;
        do_run(dc, r);
        checks++;
        if (dc !== 20 || r !== 32'd4) begin
            errors++;
            $display("[TB] FAIL midrst_rerun: done cycle %0d return %0d expected 20 and 4", dc, r);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        first_done  = -1;
        second_done = -1;
        clear_mem();
        bli_mem[0]  = 32'd16384;
        dlti_mem[0] = 32'd1;
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge ap_clk);
            if (ap_done && first_done < 0) begin
                first_done = c;
            end else if (ap_done && ap_ready) begin
                second_done = c;
                break;
            end
            if (c == 21) begin
                checks++;
                if ({ap_idle, ap_done} !== 2'b00 || ap_return !== 32'd1) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap: idle/done %b return %0d expected 00 and 1",
                             {ap_idle, ap_done}, ap_return);
                end
                @(posedge ap_clk);
                #1 ap_start = 1'b0;
            end
        end
        ap_start = 1'b0;
        checks++;
        if (first_done !== 20 || second_done !== 41) begin
            errors++;
            $display("[TB] FAIL b2b_latency: done cycles %0d,%0d expected 20,41", first_done, second_done);
        end
        repeat (3) @(negedge ap_clk);
        checks++;
        if (ap_return !== 32'd1) begin
            errors++;
            $display("[TB] FAIL b2b_hold: got %0d expected %0d", ap_return, 1);
        end
    endtask

`ifdef FILTEZ_KEY_LOCK_EN
    task automatic test_key();
        int          dc;
        logic [31:0] r;
        clear_mem();
        working_key = 8'hA4;
        do_run(dc, r);
        checks++;
        if (r !== 32'd1) begin
            errors++;
            $display("[TB] FAIL key_wrong: got %0d expected %0d", r, 1);
        end
        working_key = KEY;
        do_run(dc, r);
        checks++;
        if (r !== 32'd0) begin
            errors++;
            $display("[TB] FAIL key_right: got %0d expected %0d", r, 0);
        end
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
`ifdef FILTEZ_KEY_LOCK_EN
        working_key = KEY;
`endif
        clear_mem();
        test_reset();
        test_zero_coeffs();
        test_unit_tap();
        test_negative();
        test_full_scale();
        test_mid_reset();
        test_back_to_back();
`ifdef FILTEZ_KEY_LOCK_EN
        test_key();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filtez.md
Name: filtez

Overview:
- Zero-predictor filter of the ADPCM encoder/decoder datapath; it is the read side of the coefficient/history arrays maintained by the zero-coefficient updater.
- Reads NTAPS pairs (bli[i], dlti[i]) from the same single-port RAM interfaces, multiply-accumulates them at 64-bit signed precision, and returns acc >> SHIFT as a 32-bit value.
- Controlled by the codebase's ap_ctrl_hs start/done/idle/ready handshake.

Parameters:
- NTAPS, 6, number of taps read; index 0..NTAPS-1; must be ≤ 2^ADDR_W.
- ADDR_W, 3, RAM address width.
- SHIFT, 14, arithmetic right shift applied to the final accumulator.
- KEY_VALUE, 8'hA5, correct unlock key; used only with FILTEZ_KEY_LOCK_EN.

Ports:
- ap_clk in 1: sole clock, rising edge.
- ap_rst in 1: synchronous, active-high reset.
- ap_start in 1: start request.
- ap_done out 1: completion strobe.
- ap_idle out 1: block idle.
- ap_ready out 1: ready for new input.
- bli_address0 out ADDR_W: coefficient RAM address.
- bli_ce0 out 1: coefficient RAM read enable.
- bli_q0 in 32: coefficient read data, signed, 1-cycle latency.
- dlti_address0 out ADDR_W: history RAM address.
- dlti_ce0 out 1: history RAM read enable.
- dlti_q0 in 32: history read data, signed, 1-cycle latency.
- ap_return out 32: signed filter output, registered.

Behaviour:
- Interface: one clock ap_clk; ap_rst is synchronous, active-high.
- Reset value: FSM=S_IDLE, tap counter i=0, acc=0, ap_return=0. All ce outputs 0. Addresses are don't-care (drive 0).
- FSM is one-hot, 5 states.
  - S_IDLE:
    - ap_start=1 → S_ISSUE, with i←0 and acc←0.
    - Otherwise stay in S_IDLE.
  - S_ISSUE:
    - i==NTAPS → S_DONE.
    - Else drive bli_address0=dlti_address0=i and bli_ce0=dlti_ce0=1 → S_MUL.
  - S_MUL: q data valid this cycle. prod_reg ← $signed(bli_q0) * $signed(dlti_q0), 64-bit signed → S_ACC.
  - S_ACC: acc ← acc + prod_reg (64-bit, wraps modulo 2^64, no saturation); i←i+1 → S_ISSUE.
  - S_DONE:
    - ap_return ← acc[SHIFT+31:SHIFT], i.e. arithmetic shift with floor rounding.
    - ap_done=1, ap_ready=1 → S_IDLE.
- ap_done is combinationally 1 in S_DONE, or in S_IDLE when ap_start=0 (codebase ap_ctrl_hs convention).
- ap_idle = S_IDLE & !ap_start.
- ap_ready is 1 only in S_DONE.
- Latency with NTAPS=6: start sampled in cycle 0, ap_done pulses in cycle 20 (3*NTAPS+2). ap_return is valid from cycle 21 and held until the next S_DONE.
- ap_start held high through S_DONE: re-accepted in the next S_IDLE cycle, giving a back-to-back run with a 1-cycle gap.
- ap_start is ignored outside S_IDLE.
- ap_rst mid-operation: next edge forces S_IDLE, clears acc and ap_return, deasserts ce. No partial result is produced.
- RAM is read-only here; no write enables exist. Contents are assumed stable for the duration of a run (caller's responsibility).

Optional Feature:
- Macro: FILTEZ_KEY_LOCK_EN.
- Defined:
  - Adds input port working_key [7:0], placed after ap_return.
  - On start, acc initialises to ({56'b0, working_key ^ KEY_VALUE} << SHIFT) instead of 0.
  - With working_key==KEY_VALUE, results are identical to the unlocked build.
  - With a wrong key, ap_return is offset by (working_key^KEY_VALUE).
- Undefined: no working_key port; acc initialises to 0.

Test Plan:
- All bli=0, dlti arbitrary, start pulse → ap_done in cycle 20, ap_return=0; ap_ready=1 in the same cycle only.
- bli[0]=16384, dlti[0]=1, other taps 0 → ap_return=1.
- bli[0]=-16384, dlti[0]=3 → ap_return=-3 (0xFFFFFFFD). Separately, bli[0]=-1, dlti[0]=1 → 0xFFFFFFFF (floor rounding).
- All six bli=dlti=32767 → ap_return=393192; verify the address sequence 0..5 with ce high only in S_ISSUE.
- Assert ap_rst in cycle 10 of a run, then start a fresh run with bli[5]=32768, dlti[5]=2 → ap_return=0 immediately after reset, then 4.
- FILTEZ_KEY_LOCK_EN with working_key=8'hA5 matches the unlocked build on all cases above. With working_key=8'hA4 and all-zero RAM → ap_return=1.
